// File: rtl/axi_slave_regs_pkg.sv
// Shared definitions for the AXI4-Lite register slave:
// response codes, FSM encodings and the byte-lane merge helper.
package axi_slave_regs_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Merge new data into an old word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
// Signal names follow the AXI S_AXI_* naming of the slave ports.
interface axi_slave_regs_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;

    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;

    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;

    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;

    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/axi_slave_regs.sv
// AXI4-Lite slave with NUM_REGS RW control registers and one
// read-only status word directly above them; anything higher errors.
module axi_slave_regs
    import axi_slave_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 8
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    axi_slave_regs_if.slave                        s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int LOG2   = $clog2(NUM_REGS);
    localparam int IDX_W  = LOG2 + 1;
    localparam int IDX_HI = LOG2 + 2;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic             aw_held, w_held;
    logic [IDX_W-1:0] aw_idx;
    logic [DW-1:0]    wdata_q;
    logic [SW-1:0]    wstrb_q;
    logic             awready, wready, bvalid, commit;
    logic [1:0]       bresp;

    logic             arready, rvalid, ar_hs;
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    rdata, rd_data;
    logic [1:0]       rresp, rd_resp;

    logic [NUM_REGS-1:0][DW-1:0] regs;

    // Address bits outside the word index carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{
        s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IDX_HI+1],
        s_axi.S_AXI_AWADDR[1:0],
        s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IDX_HI+1],
        s_axi.S_AXI_ARADDR[1:0]
    };

    assign ar_idx    = s_axi.S_AXI_ARADDR[IDX_HI:2];
    assign ctrl_regs = regs;

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = rresp;

    // Write FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM: accept AW/W in any order, commit once both are held.
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        commit  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = !aw_held && !S_AXI_ARESET;
                wready  = !w_held && !S_AXI_ARESET;
                if (aw_held && w_held) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.S_AXI_BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Hold the AW index and W payload until the commit cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (awready && s_axi.S_AXI_AWVALID) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi.S_AXI_AWADDR[IDX_HI:2];
            end
            if (wready && s_axi.S_AXI_WVALID) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi.S_AXI_WDATA;
                wstrb_q <= s_axi.S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Register commit, write pulse and the response code it earns.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            regs     <= '0;
            wr_pulse <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                if (!aw_idx[LOG2]) begin
                    regs[aw_idx[LOG2-1:0]] <= apply_strb(
                        regs[aw_idx[LOG2-1:0]], wdata_q, wstrb_q);
                    wr_pulse[aw_idx[LOG2-1:0]] <= 1'b1;
                    bresp <= RESP_OKAY;
                end else begin
                    bresp <= RESP_SLVERR;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM: one outstanding read, data held until RREADY.
    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = !S_AXI_ARESET;
                if (s_axi.S_AXI_ARVALID && !S_AXI_ARESET) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (s_axi.S_AXI_RREADY) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs = arready && s_axi.S_AXI_ARVALID;

    // Read decode: RW bank, then status word, then error hole.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (!ar_idx[LOG2]) begin
            rd_data = regs[ar_idx[LOG2-1:0]];
            rd_resp = RESP_OKAY;
        end else if (ar_idx[LOG2-1:0] == '0) begin
            rd_data = status_in;
            rd_resp = RESP_OKAY;
        end
    end

    // Sample read data at the AR handshake so it sees pre-commit values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= rd_data;
            rresp <= rd_resp;
        end
    end

endmodule

// File: tb/tb_axi_slave_regs.sv
// Scoreboard bench for axi_slave_regs: expected B/R responses are
// queued at stimulus time and popped when the DUT hands them over.
module tb_axi_slave_regs;

    localparam int NR = 8;
    localparam int AW = 32;
    localparam int FW = NR * 32;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] ctrl_regs;
    logic [NR-1:0] wr_pulse;
    logic [31:0]   status_in;

    axi_slave_regs_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    axi_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .s_axi(bus),
        .ctrl_regs(ctrl_regs),
        .wr_pulse(wr_pulse),
        .status_in(status_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int b_count = 0;
    int r_count = 0;
    int n_wr = 0;
    int n_rd = 0;
    rsp_t exp_b[$];
    rsp_t exp_r[$];
    logic [31:0] mdl [NR];

    task automatic check(input string tag,
                         input logic [FW-1:0] got,
                         input logic [FW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [FW-1:0] flat_model();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = mdl[i];
        return f;
    endfunction

    // Response monitors: pop and compare on each completed handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
            b_count++;
            if (exp_b.size() == 0) begin
                check("b_unexp", FW'(bus.S_AXI_BVALID), FW'(0));
            end else begin
                e = exp_b.pop_front();
                check("bresp", FW'(bus.S_AXI_BRESP), FW'(e.resp));
            end
        end
        if (!rst && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
            r_count++;
            if (exp_r.size() == 0) begin
                check("r_unexp", FW'(bus.S_AXI_RVALID), FW'(0));
            end else begin
                e = exp_r.pop_front();
                check("rresp", FW'(bus.S_AXI_RRESP), FW'(e.resp));
                check("rdata", FW'(bus.S_AXI_RDATA), FW'(e.data));
            end
        end
    end

    task automatic exp_write(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0]  strb,
                             output logic [NR-1:0] pulse);
        int   i;
        rsp_t e;
        i = int'(addr[5:2]);
        pulse = '0;
        e.data = '0;
        if (i < NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[i][8*b +: 8] = data[8*b +: 8];
            pulse[i] = 1'b1;
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b10;
        end
        exp_b.push_back(e);
        n_wr++;
    endtask

    task automatic exp_read(input logic [31:0] addr);
        int   i;
        rsp_t e;
        i = int'(addr[5:2]);
        if (i < NR) begin
            e.data = mdl[i];
            e.resp = 2'b00;
        end else if (i == NR) begin
            e.data = status_in;
            e.resp = 2'b00;
        end else begin
            e.data = '0;
            e.resp = 2'b10;
        end
        exp_r.push_back(e);
        n_rd++;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        logic ok;
        ok = 1'b0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.S_AXI_AWREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("aw_timeout", FW'(ok), FW'(1));
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        logic ok;
        ok = 1'b0;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        bus.S_AXI_WVALID = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.S_AXI_WREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("w_timeout", FW'(ok), FW'(1));
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        logic ok;
        ok = 1'b0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ar_timeout", FW'(ok), FW'(1));
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    // W leads AW by 'lead' cycles (0 = same cycle).
    task automatic do_write(input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [3:0]  strb,
                            input int          lead);
        logic [NR-1:0] pulse;
        int lat;
        exp_write(addr, data, strb, pulse);
        if (lead == 0) begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end else begin
            send_w(data, strb);
            if (lead > 1) begin
                repeat (lead - 1) @(posedge clk);
                #1;
            end
            send_aw(addr);
        end
        lat = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            lat++;
            if (bus.S_AXI_BVALID) break;
        end
        check("b_latency", FW'(lat), FW'(2));
        check("wr_pulse", FW'(wr_pulse), FW'(pulse));
        check("ctrl_regs", ctrl_regs, flat_model());
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic ok;
        exp_read(addr);
        send_ar(addr);
        ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("r_timeout", FW'(ok), FW'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_ready(input string tag, input logic v);
        check({tag, "_awready"}, FW'(bus.S_AXI_AWREADY), FW'(v));
        check({tag, "_wready"}, FW'(bus.S_AXI_WREADY), FW'(v));
        check({tag, "_arready"}, FW'(bus.S_AXI_ARREADY), FW'(v));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] p;
        logic [31:0]   a, d;
        rst = 1'b1;
        status_in = 32'hA5A5A5A5;
        bus.S_AXI_AWADDR = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_ready("rst", 1'b0);
        check("rst_bvalid", FW'(bus.S_AXI_BVALID), FW'(0));
        check("rst_rvalid", FW'(bus.S_AXI_RVALID), FW'(0));
        check("rst_bresp", FW'(bus.S_AXI_BRESP), FW'(0));
        check("rst_rresp", FW'(bus.S_AXI_RRESP), FW'(0));
        check("rst_rdata", FW'(bus.S_AXI_RDATA), FW'(0));
        check("rst_ctrl", ctrl_regs, '0);
        check("rst_pulse", FW'(wr_pulse), FW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_ready("rel", 1'b1);
        @(posedge clk); #1;

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0);
        check("reg1", FW'(ctrl_regs[63:32]), FW'(32'hDEADBEEF));

        do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0);
        do_write(32'h08, 32'h12345678, 4'h3, 3);
        repeat (4) @(posedge clk);
        #1;
        check("reg2", FW'(ctrl_regs[95:64]), FW'(32'hFFFF5678));
        check("one_resp", FW'(b_count), FW'(n_wr));

        do_read(32'h20);
        do_write(32'h20, 32'h11111111, 4'hF, 0);

        bus.S_AXI_RREADY = 1'b0;
        exp_read(32'h24);
        send_ar(32'h24);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rvalid", FW'(bus.S_AXI_RVALID), FW'(1));
            check("hold_rdata", FW'(bus.S_AXI_RDATA), FW'(0));
            check("hold_rresp", FW'(bus.S_AXI_RRESP), FW'(2'b10));
        end
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;

        do_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0);

        exp_read(32'h00);
        exp_write(32'h00, 32'h1, 4'h1, p);
        fork
            send_aw(32'h00);
            send_w(32'h1, 4'h1);
        join
        send_ar(32'h00);
        @(negedge clk);
        check("same_edge_b", FW'(bus.S_AXI_BVALID), FW'(1));
        check("same_edge_r", FW'(bus.S_AXI_RVALID), FW'(1));
        check("same_edge_p", FW'(wr_pulse), FW'(p));
        @(posedge clk); #1;
        do_read(32'h00);

        do_write(32'h44, 32'hCAFEF00D, 4'hF, 1);
        do_read(32'h07);
        do_read(32'h3C);

        for (int n = 0; n < 12; n++) begin
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            do_write(a, d, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2));
            status_in = $urandom;
            do_read(32'($urandom_range(0, 63)));
        end

        send_aw(32'h04);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_ready("mid_rst", 1'b0);
        check("mid_rst_bvalid", FW'(bus.S_AXI_BVALID), FW'(0));
        check("mid_rst_ctrl", ctrl_regs, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        @(negedge clk);
        check_ready("mid_rel", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("no_resp_after_rst", FW'(b_count), FW'(n_wr));
        check("ctrl_after_rst", ctrl_regs, flat_model());

        check("b_queue_empty", FW'(exp_b.size()), FW'(0));
        check("r_queue_empty", FW'(exp_r.size()), FW'(0));
        check("r_total", FW'(r_count), FW'(n_rd));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_slave_regs.md
AXI_SLAVE_REGS -- requirements
Module: axi_slave_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of read/write control registers (power of two, 2..16).
REQ-004 SHALL provide one clock and a synchronous, active-high reset, exactly as: one clock; reset is synchronous and active-high.
REQ-005 S_AXI_ACLK  input  1  sole clock; all logic on rising edge.
REQ-006 S_AXI_ARESET  input  1  synchronous active-high reset.
REQ-007 S_AXI_AWADDR  input  ADDR_W  write address; S_AXI_AWVALID input 1; S_AXI_AWREADY output 1.
REQ-008 S_AXI_WDATA  input  32; S_AXI_WSTRB  input  4  byte enables; S_AXI_WVALID  input  1; S_AXI_WREADY  output  1.
REQ-009 S_AXI_BRESP  output  2; S_AXI_BVALID  output  1; S_AXI_BREADY  input  1.
REQ-010 S_AXI_ARADDR  input  ADDR_W; S_AXI_ARVALID  input  1; S_AXI_ARREADY  output  1.
REQ-011 S_AXI_RDATA  output  32; S_AXI_RRESP  output  2; S_AXI_RVALID  output  1; S_AXI_RREADY  input  1.
REQ-012 ctrl_regs  output  NUM_REGS*32  flattened control registers, reg i at bits [32i+31:32i].
REQ-013 wr_pulse  output  NUM_REGS  one-cycle pulse, bit i set in the cycle after reg i is written.
REQ-014 status_in  input  32  read-only status word, mapped at word index NUM_REGS.

Function
REQ-015 Word index = ADDR[2+log2(NUM_REGS):2]; address bits [1:0] ignored; bits above the index SHALL be ignored.
REQ-016 Indices 0..NUM_REGS-1 SHALL be RW; index NUM_REGS SHALL read status_in and return OKAY, with writes discarded and SLVERR (2'b10) returned; any higher index SHALL return SLVERR, read data 0, no register change.
REQ-017 Write FSM states: W_IDLE, W_RESP. In W_IDLE, AWREADY SHALL be high until AW is captured and WREADY SHALL be high until W is captured; AW and W SHALL be accepted in either order or in the same cycle.
REQ-018 In the cycle after both AW and W are held, the write SHALL commit with per-byte WSTRB masking, BVALID SHALL assert, and the FSM SHALL enter W_RESP.
REQ-019 In W_RESP, AWREADY/WREADY SHALL be low; BVALID and BRESP SHALL hold stable until BVALID&BREADY, after which the FSM SHALL return to W_IDLE on the next cycle.
REQ-020 Read FSM states: R_IDLE, R_DATA. In R_IDLE, ARREADY=1; on ARVALID, ARADDR SHALL be captured and the FSM SHALL enter R_DATA, with RVALID high on the following cycle.
REQ-021 RDATA/RRESP SHALL be sampled at the AR handshake edge and held stable until RVALID&RREADY; ARREADY SHALL be low in R_DATA.
REQ-022 If a write commit and a read handshake occur on the same edge to the same register, the read SHALL return the pre-write value.
REQ-023 Read and write channels SHALL operate concurrently and independently.
REQ-024 WSTRB=0 SHALL complete with OKAY, no data change, and wr_pulse still asserted.

Reset
REQ-025 On S_AXI_ARESET=1 at a clock edge: both FSMs idle; AWREADY=WREADY=ARREADY=0 during reset, and 1 from the first cycle after release; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; ctrl_regs=0; wr_pulse=0; captured-address flags cleared.
REQ-026 Reset mid-transaction SHALL abort it with no register update and no response issued.

Structure
REQ-027 A shared package SHALL hold the RESP_OKAY/RESP_SLVERR constants and the FSM state encodings.
REQ-028 The implementation SHALL be a single module with no sub-modules.

Verification
REQ-029 AW and W in the same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 0xF -> BVALID 1 cycle later, BRESP=0, reg1=0xDEADBEEF, wr_pulse=0b0000_0010.
REQ-030 W 3 cycles before AW, addr 0x08, data 0x12345678, WSTRB 0x3, reg2 previously 0xFFFFFFFF -> reg2=0xFFFF5678, exactly one response.
REQ-031 Read addr 0x20 with status_in=0xA5A5A5A5 -> RDATA=0xA5A5A5A5, RRESP=0; write to 0x20 -> BRESP=2'b10, no register change.
REQ-032 Read addr 0x24 -> RRESP=2'b10, RDATA=0; hold RREADY low 5 cycles -> RVALID/RDATA stable throughout.
REQ-033 Same-edge write of 0x1 and read of reg0 (old value 0x0) -> RDATA=0x0; subsequent read -> 0x1.
REQ-034 Assert reset with AW captured and W pending -> no BVALID, ctrl_regs all 0, READY signals 0 during reset and 1 one cycle after release.
